if_stage: RTL and testbench

- Instruction fetch stage of the RISC-V core; the producer side of the decode stage's instruction interface.
- Holds the PC and issues in-order fetch requests to instruction memory (valid/ready request, in-order response).
- Buffers returned words in a small FIFO and presents inst/inst_pc/inst_valid to decode under a ready/valid handshake.
- Supports redirect (branch/jump) with flush of buffered and in-flight fetches.

---
 rtl/if_stage.sv | 120 ++++++++++++
 tb/tb_if_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, in-order imem requests, small response
// buffer feeding decode, and redirect with flush of buffered and in-flight fetches.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned LVL_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [31:0]      buf_inst_q [BUF_DEPTH];
    logic [31:0]      buf_pc_q   [BUF_DEPTH];

    logic             accept;
    logic             push;
    logic             pop;
    logic [LVL_W-1:0] level;
    logic [31:0]      target_pc;

    // Entries committed after this cycle's pop; outstanding includes words still to be dropped.
    assign level     = LVL_W'(count_q) + LVL_W'(outst_q) - LVL_W'(pop);
    assign imem_req  = ~reset & ~redirect & (level < LVL_W'(BUF_DEPTH));
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req & imem_ready;
    assign push      = imem_rvalid & ~redirect & (drop_q == '0);
    assign pop       = inst_valid & id_ready;
    assign target_pc = redirect_pc & ~32'h3;

    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? buf_inst_q[rd_ptr_q] : NOP;
    assign inst_pc    = inst_valid ? buf_pc_q[rd_ptr_q]   : 32'h0;

    // Next-state logic for PCs, buffer pointers and in-flight bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CNT_W'(accept) - CNT_W'(imem_rvalid);

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end
        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Redirect flushes the buffer; everything still in flight belongs to the old stream.
        if (redirect) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_d     = outst_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // Buffer storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: in-order memory model plus a stream-level
// scoreboard of the PCs decode must see after each reset or redirect.
module tb_if_stage;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    if_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    int          cycle;
    int          n_chk, n_pass;
    logic [31:0] exp_fetch, exp_pc;

    int          ready_pct, rv_pct, lat_min, lat_max, id_pct, redir_pm, ready_hold;
    int          redir_at;
    logic [31:0] redir_at_pc;
    int          redir_rv_cnt;
    logic [31:0] redir_rv_pc;
    int          expect_req_cyc;
    int          first_acc, first_val, n_acc;
    bit          zero_phase, saw_wrap, prev_hold;
    logic [31:0] last_acc, prev_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    endtask

    task automatic drive_inputs();
        imem_ready  = (cycle >= ready_hold) && ($urandom_range(99) < ready_pct);
        id_ready    = ($urandom_range(99) < id_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_q.size() > 0 && mem_q[0].due <= cycle && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr | 32'h1;
        end
        redirect    = 1'b0;
        redirect_pc = $urandom;
        if (cycle == redir_at) begin
            redirect    = 1'b1;
            redirect_pc = redir_at_pc;
        end else if (redir_rv_cnt > 0 && imem_rvalid) begin
            redir_rv_cnt--;
            if (redir_rv_cnt == 0) begin
                redirect       = 1'b1;
                redirect_pc    = redir_rv_pc;
                expect_req_cyc = cycle + 1;
            end
        end else if (int'($urandom_range(999)) < redir_pm) begin
            redirect = 1'b1;
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        end
    endtask

    task automatic sample();
        if (!inst_valid) begin
            chk("idle_inst", inst, NOP);
            chk("idle_pc", inst_pc, 32'h0);
        end
        if (prev_hold) begin
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_pc", inst_pc, prev_pc);
        end
        if (redirect) chk("req_in_redirect", 32'(imem_req), 32'd0);
        if (cycle == expect_req_cyc) begin
            chk("req_after_redirect", 32'(imem_req), 32'd1);
            chk("addr_after_redirect", imem_addr, redir_rv_pc & ~32'h3);
        end
        if (inst_valid && first_val < 0) begin
            first_val = cycle;
            if (zero_phase) chk("first_latency", 32'(first_val - first_acc), 32'd2);
        end
        if (zero_phase) begin
            chk("zero_wait_req", 32'(imem_req), 32'd1);
            if (first_val >= 0 && cycle > first_val) chk("no_gap", 32'(inst_valid), 32'd1);
        end
        if (imem_req) chk("imem_addr", imem_addr, exp_fetch);
        if (imem_req && imem_ready) begin
            mem_q.push_back('{addr: imem_addr, due: cycle + int'($urandom_range(lat_max, lat_min))});
            if (last_acc == 32'hFFFF_FFFC && imem_addr == 32'h0) saw_wrap = 1'b1;
            last_acc = imem_addr;
            if (first_acc < 0) first_acc = cycle;
            exp_fetch = exp_fetch + 32'd4;
            n_acc++;
        end
        if (imem_rvalid) void'(mem_q.pop_front());
        if (inst_valid && id_ready) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, exp_pc | 32'h1);
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect) begin
            exp_fetch = redirect_pc & ~32'h3;
            exp_pc    = redirect_pc & ~32'h3;
        end
        chk("outstanding_bound", 32'(mem_q.size() <= DEPTH), 32'd1);
        chk("fetch_ahead_bound", 32'(((exp_fetch - exp_pc) >> 2) <= 32'(DEPTH)), 32'd1);
        prev_hold = inst_valid && !id_ready && !redirect;
        prev_pc   = inst_pc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_inputs();
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
            cycle++;
        end
    endtask

    // Asserted mid-cycle so reset values are observed asynchronously.
    task automatic do_reset();
        reset = 1'b1;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        mem_q.delete();
        exp_fetch = RST_PC; exp_pc = RST_PC;
        first_acc = -1; first_val = -1; n_acc = 0;
        saw_wrap = 1'b0; prev_hold = 1'b0; last_acc = 32'h0; prev_pc = 32'h0;
        redir_at = -1; redir_rv_cnt = 0; expect_req_cyc = -1; zero_phase = 1'b0;
        ready_pct = 100; rv_pct = 100; lat_min = 1; lat_max = 1; id_pct = 100;
        redir_pm = 0; ready_hold = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle = 0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cycle = 0;
        do_reset();

        // Zero-wait memory, decode always ready.
        zero_phase = 1'b1;
        run(20);
        zero_phase = 1'b0;
        chk("latency_seen", 32'(first_val >= 0), 32'd1);

        // Decode stalled: fetch stops once the buffer budget is used.
        do_reset();
        id_pct = 0;
        run(8);
        chk("stall_req_off", 32'(imem_req), 32'd0);
        chk("stall_head_valid", 32'(inst_valid), 32'd1);
        chk("stall_head_pc", inst_pc, 32'h0);
        chk("stall_head_inst", inst, 32'h1);
        chk("stall_fetch_count", 32'(n_acc), 32'(DEPTH));
        id_pct = 100;
        run(10);

        // Memory not ready for 3 cycles, then 3-cycle response latency.
        do_reset();
        ready_hold = 3; lat_min = 3; lat_max = 3;
        run(20);

        // Redirect with two fetches in flight.
        do_reset();
        lat_min = 3; lat_max = 3;
        redir_at = 2; redir_at_pc = 32'h0000_0103;
        run(20);
        chk("redirect_stream_advanced", 32'(exp_pc >= 32'h108 && exp_pc < 32'h200), 32'd1);

        // Redirect coincident with a response while the buffer holds data.
        do_reset();
        id_pct = 0; lat_min = 2; lat_max = 2;
        redir_rv_cnt = 2; redir_rv_pc = 32'h0000_0202;
        run(12);
        id_pct = 100;
        run(10);
        chk("rv_redirect_stream", 32'(exp_pc >= 32'h204), 32'd1);

        // PC wrap at the top of the address space.
        do_reset();
        redir_at = 1; redir_at_pc = 32'hFFFF_FFF8;
        run(15);
        chk("pc_wrap", 32'(saw_wrap), 32'd1);

        // Randomized traffic with varying memory, decode and redirect behaviour.
        do_reset();
        for (int p = 0; p < 15; p++) begin
            ready_pct = int'($urandom_range(100, 30));
            rv_pct    = int'($urandom_range(100, 40));
            lat_min   = int'($urandom_range(2, 1));
            lat_max   = lat_min + int'($urandom_range(3, 0));
            id_pct    = int'($urandom_range(100, 20));
            redir_pm  = int'($urandom_range(60, 0));
            run(200);
        end

        // Reset in the middle of the stream.
        do_reset();
        run(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
